// File: rtl/fetch_unit.sv
// fetch_unit -- instruction fetch stage ahead of the MIPS decode logic.
//
// Owns the fetch PC, issues one word request at a time to instruction memory
// over a req/ack handshake, buffers returned words with their PCs in a
// DEPTH-entry prefetch FIFO and hands them to the core over valid/ready.
// A redirect flushes the FIFO and restarts fetch at the new target; a
// response already in flight when the redirect arrives is dropped.
//
// Parameters:
//   DEPTH     prefetch FIFO entries (power of two, >= 2)
//   RESET_PC  fetch PC loaded at reset
//
// Ports:
//   clk          clock, rising edge
//   R            asynchronous active-low reset
//   imem_req     request outstanding to instruction memory (registered)
//   imem_addr    word-aligned byte address of the request (registered)
//   imem_ack     memory completes the current request this cycle
//   imem_data    instruction word, valid with imem_ack
//   redirect     taken branch/jump: flush and refetch
//   redirect_pc  new fetch target, bits [1:0] ignored
//   instr_valid  FIFO head holds an instruction
//   instr        FIFO head instruction word
//   instr_pc     FIFO head instruction address
//   instr_ready  core accepts the head this cycle
//
// Optional feature (macro FETCH_STATS_EN):
//   stat_fetched    saturating count of words pushed into the FIFO
//   stat_discarded  saturating count of dropped responses plus entries
//                   cleared by flushes
module fetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        R,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
`ifdef FETCH_STATS_EN
  ,
  output logic [15:0] stat_fetched,
  output logic [15:0] stat_discarded
`endif
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [31:0] RST_PC = {RESET_PC[31:2], 2'b00};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_DISCARD = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   addr_d;
  logic [31:0]   target;
  logic [31:0]   fifo_pc   [DEPTH];
  logic [31:0]   fifo_word [DEPTH];
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] count_after_push;
  logic          push;
  logic          pop;
  logic          flush;

  assign target           = redirect_pc & 32'hFFFF_FFFC;
  assign flush            = redirect;
  assign instr_valid      = (count_q != '0);
  assign instr            = fifo_word[rd_ptr_q];
  assign instr_pc         = fifo_pc[rd_ptr_q];
  assign pop              = instr_valid && instr_ready;
  assign count_after_push = count_q + CW'(1) - CW'(pop);

  // The address stays frozen while a request is still waiting for its ack,
  // even if a redirect has already moved fetch_pc on (DISCARD); otherwise it
  // tracks the next fetch PC so it is ready for the next issue.
  assign addr_d = ((state_q != ST_IDLE) && !imem_ack) ? imem_addr : fetch_pc_d;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    push       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (redirect) begin
          fetch_pc_d = target;
        end else if (count_q < FULL) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (redirect) begin
          fetch_pc_d = target;
          state_d    = imem_ack ? ST_IDLE : ST_DISCARD;
        end else if (imem_ack) begin
          push       = 1'b1;
          fetch_pc_d = fetch_pc_q + 32'd4;
          // Keep streaming only while the slot for the next word is free.
          if (count_after_push >= FULL) begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DISCARD: begin
        if (redirect) begin
          fetch_pc_d = target;
        end
        if (imem_ack) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else begin
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RST_PC;
      imem_addr  <= RST_PC;
      imem_req   <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      imem_addr  <= addr_d;
      imem_req   <= (state_d != ST_IDLE);
    end
  end

  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fifo_pc[i]   <= '0;
        fifo_word[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      if (flush) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (push) begin
          fifo_pc[wr_ptr_q]   <= fetch_pc_q;
          fifo_word[wr_ptr_q] <= imem_data;
          wr_ptr_q            <= wr_ptr_q + PW'(1);
        end
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + PW'(1);
        end
      end
    end
  end

`ifdef FETCH_STATS_EN
  logic          drop;
  logic [CW-1:0] cleared;
  logic [16:0]   fetched_sum;
  logic [16:0]   discarded_sum;

  // A response is dropped when it completes a request that a redirect has
  // already invalidated, or one that is invalidated in the same cycle.
  assign drop = imem_ack &&
                ((state_q == ST_DISCARD) || ((state_q == ST_WAIT) && redirect));
  // An entry popped in the flush cycle was delivered, so it is not counted.
  assign cleared       = flush ? (count_q - CW'(pop)) : '0;
  assign fetched_sum   = {1'b0, stat_fetched} + 17'(push);
  assign discarded_sum = {1'b0, stat_discarded} + 17'(drop) + 17'(cleared);

  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      stat_fetched   <= '0;
      stat_discarded <= '0;
    end else begin
      stat_fetched   <= fetched_sum[16]   ? '1 : fetched_sum[15:0];
      stat_discarded <= discarded_sum[16] ? '1 : discarded_sum[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized
// run, with a behavioural model of the delivered instruction stream.
module tb_fetch_unit;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        R = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_data = '0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready = 1'b0;
`ifdef FETCH_STATS_EN
  logic [15:0] stat_fetched;
  logic [15:0] stat_discarded;
`endif

  always #5 clk = ~clk;

  fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .R           (R),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_data   (imem_data),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready)
`ifdef FETCH_STATS_EN
    ,
    .stat_fetched   (stat_fetched),
    .stat_discarded (stat_discarded)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Memory contents: an address-dependent word so misplaced data is visible.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h3C5A_96E1;
  endfunction

  // ---------------- instruction memory responder ----------------
  typedef enum int {MEM_TIE, MEM_DELAY, MEM_RAND, MEM_OFF} mem_mode_t;
  mem_mode_t   mem_mode = MEM_OFF;
  int unsigned mem_dly_fixed = 0;
  int unsigned mem_cnt = 0;
  int unsigned mem_dly = 0;

  task automatic tick();
    bit done_last;
    done_last = imem_req && imem_ack;
    @(posedge clk);
    #1;
    redirect = 1'b0;
    case (mem_mode)
      MEM_TIE: imem_ack = 1'b1;
      MEM_OFF: ;
      default: begin
        if (done_last || !imem_req) begin
          mem_cnt = 0;
          mem_dly = (mem_mode == MEM_RAND) ? $urandom_range(0, 3) : mem_dly_fixed;
        end
        if (imem_req) begin
          imem_ack = (mem_cnt >= mem_dly);
          mem_cnt++;
        end else begin
          imem_ack = (mem_mode == MEM_RAND) ? ($urandom_range(0, 3) == 0) : 1'b0;
        end
      end
    endcase
    imem_data = mem_word(imem_addr);
  endtask

  task automatic do_reset();
    R = 1'b0;
    tick();
    tick();
    R = 1'b1;
  endtask

  // ---------------- behavioural stream model ----------------
  // The core must see consecutive word addresses starting at the reset PC or
  // the latest redirect target, each with the memory word for that address.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } entry_t;

  entry_t      q[$];
  logic [31:0] exp_pc = RESET_PC & 32'hFFFF_FFFC;
  bit          outstanding = 1'b0;
  bit          kept = 1'b0;
  bit          hold_prev = 1'b0;
  logic [31:0] prev_addr = '0;
  int unsigned n_pops = 0;
  int unsigned m_fetched = 0;
  int unsigned m_discarded = 0;

  function automatic logic [31:0] sat16(input int unsigned v);
    return (v > 32'hFFFF) ? 32'hFFFF : v;
  endfunction

  always @(negedge clk) begin
    entry_t e;
    if (!R) begin
      q.delete();
      exp_pc      = RESET_PC & 32'hFFFF_FFFC;
      outstanding = 1'b0;
      kept        = 1'b0;
      hold_prev   = 1'b0;
      m_fetched   = 0;
      m_discarded = 0;
    end else begin
      check("valid", 32'(instr_valid), 32'(q.size() != 0));
      if (q.size() != 0) begin
        check("instr_pc", instr_pc, q[0].pc);
        check("instr", instr, q[0].word);
      end
      check("addr_align", imem_addr & 32'h3, 32'h0);
`ifdef FETCH_STATS_EN
      check("stat_fetched", 32'(stat_fetched), sat16(m_fetched));
      check("stat_discarded", 32'(stat_discarded), sat16(m_discarded));
`endif
      if (hold_prev) begin
        check("req_held", 32'(imem_req), 32'h1);
        check("addr_held", imem_addr, prev_addr);
      end
      if (imem_req && !outstanding) begin
        outstanding = 1'b1;
        kept        = 1'b1;
        check("issue_addr", imem_addr, exp_pc);
      end
      if (q.size() != 0 && instr_ready) begin
        void'(q.pop_front());
        n_pops++;
      end
      if (imem_req && imem_ack) begin
        if (kept && !redirect) begin
          e.pc   = exp_pc;
          e.word = mem_word(exp_pc);
          q.push_back(e);
          exp_pc = exp_pc + 32'd4;
          m_fetched++;
        end else begin
          m_discarded++;
        end
        outstanding = 1'b0;
      end
      if (redirect) begin
        m_discarded += unsigned'(q.size());
        q.delete();
        exp_pc = redirect_pc & 32'hFFFF_FFFC;
        kept   = 1'b0;
      end
      hold_prev = imem_req && !imem_ack;
      prev_addr = imem_addr;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int unsigned pops_before;

    // Reset values
    R = 1'b0;
    tick();
    tick();
    check("rst_req", 32'(imem_req), 32'h0);
    check("rst_addr", imem_addr, RESET_PC);
    check("rst_valid", 32'(instr_valid), 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_instr_pc", instr_pc, 32'h0);

    // Zero-wait memory, core always ready: one instruction per cycle
    mem_mode    = MEM_TIE;
    instr_ready = 1'b1;
    do_reset();
    tick();
    check("t1_first_req", 32'(imem_req), 32'h1);
    check("t1_first_addr", imem_addr, 32'h0);
    check("t1_not_valid_yet", 32'(instr_valid), 32'h0);
    for (int k = 0; k < 6; k++) begin
      tick();
      check("t1_stream_valid", 32'(instr_valid), 32'h1);
      check("t1_stream_pc", instr_pc, 32'(4 * k));
    end

    // Core stalled: FIFO fills, fetch stops at 0x10, resumes there
    instr_ready = 1'b0;
    do_reset();
    repeat (5) tick();
    check("t2_full_req", 32'(imem_req), 32'h0);
    check("t2_full_addr", imem_addr, 32'h10);
    repeat (3) tick();
    check("t2_still_idle", 32'(imem_req), 32'h0);
    instr_ready = 1'b1;
    for (int i = 0; i < 5 && !imem_req; i++) tick();
    check("t2_resume_req", 32'(imem_req), 32'h1);
    check("t2_resume_addr", imem_addr, 32'h10);
    repeat (8) tick();

    // Delayed memory, redirect while the 0x8 request is outstanding
    mem_mode      = MEM_DELAY;
    mem_dly_fixed = 3;
    do_reset();
    for (int i = 0; i < 40 && !(imem_req && imem_addr == 32'h8); i++) tick();
    check("t3_req8", imem_addr, 32'h8);
    tick();
    redirect    = 1'b1;
    redirect_pc = 32'h40;
    tick();
    check("t3_hold_req", 32'(imem_req), 32'h1);
    check("t3_hold_addr", imem_addr, 32'h8);
    for (int i = 0; i < 12 && !(imem_req && imem_addr != 32'h8); i++) tick();
    check("t3_next_addr", imem_addr, 32'h40);
    for (int i = 0; i < 12 && !instr_valid; i++) tick();
    check("t3_first_pc", instr_pc, 32'h40);
    repeat (10) tick();

    // Redirect with simultaneous ack in WAIT; target low bits ignored
    mem_mode = MEM_TIE;
    do_reset();
    for (int i = 0; i < 40 && !(imem_req && imem_addr == 32'h20); i++) tick();
    check("t4_req20", imem_addr, 32'h20);
    redirect    = 1'b1;
    redirect_pc = 32'h103;
    tick();
    check("t4_idle_req", 32'(imem_req), 32'h0);
    check("t4_idle_addr", imem_addr, 32'h100);
    check("t4_flushed", 32'(instr_valid), 32'h0);
    tick();
    check("t4_req", 32'(imem_req), 32'h1);
    check("t4_addr", imem_addr, 32'h100);
    repeat (6) tick();

    // Redirect in IDLE: request after one edge, data after two
    do_reset();
    redirect    = 1'b1;
    redirect_pc = 32'h2A0;
    tick();
    check("t5_e0_req", 32'(imem_req), 32'h0);
    tick();
    check("t5_e1_req", 32'(imem_req), 32'h1);
    check("t5_e1_addr", imem_addr, 32'h2A0);
    tick();
    check("t5_e2_valid", 32'(instr_valid), 32'h1);
    check("t5_e2_pc", instr_pc, 32'h2A0);
    repeat (4) tick();

    // Reset while a request is outstanding; late ack ignored
    mem_mode      = MEM_DELAY;
    mem_dly_fixed = 3;
    do_reset();
    for (int i = 0; i < 5 && !imem_req; i++) tick();
    tick();
    mem_mode = MEM_OFF;
    imem_ack = 1'b0;
    R        = 1'b0;
    #1;
    check("t6_rst_req", 32'(imem_req), 32'h0);
    check("t6_rst_addr", imem_addr, RESET_PC);
    check("t6_rst_valid", 32'(instr_valid), 32'h0);
    check("t6_rst_instr", instr, 32'h0);
    check("t6_rst_pc", instr_pc, 32'h0);
    tick();
    imem_ack = 1'b1;
    tick();
    R = 1'b1;
    tick();
    check("t6_no_push", 32'(instr_valid), 32'h0);
    check("t6_restart_req", 32'(imem_req), 32'h1);
    check("t6_restart_addr", imem_addr, RESET_PC);
    mem_mode = MEM_DELAY;
    repeat (10) tick();

    // Randomized traffic checked by the stream model
    mem_mode    = MEM_RAND;
    pops_before = n_pops;
    for (int c = 0; c < 3000; c++) begin
      instr_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 29) == 0) begin
        redirect    = 1'b1;
        redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                  : $urandom;
      end
      if ($urandom_range(0, 999) == 0) begin
        R = 1'b0;
        tick();
        R = 1'b1;
      end
      tick();
    end
    check("rand_progress", 32'((n_pops - pops_before) > 200), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage sitting directly upstream of the MIPS core's decode logic. It owns the fetch PC, issues word requests to an instruction memory over a req/ack handshake, buffers returned words with their PCs in a small prefetch FIFO, and presents them to the core over a valid/ready handshake. A redirect input, driven by the core's branch/jump PC-select mux, flushes the FIFO and restarts fetch at the new target.

## Interface
- DEPTH, 4, prefetch FIFO entries; power of two, minimum 2
- RESET_PC, 32'h0000_0000, fetch PC loaded at reset

- clk  input  1  clock, rising-edge active
- R  input  1  asynchronous, active-low reset
- imem_req  output  1  request to instruction memory; registered
- imem_addr  output  32  byte address of the current request; registered, bits [1:0] always 0
- imem_ack  input  1  memory completes the current request this cycle; may be high in the same cycle imem_req rises
- imem_data  input  32  instruction word, valid when imem_ack=1
- redirect  input  1  taken branch/jump; flush and refetch
- redirect_pc  input  32  new fetch target; bits [1:0] ignored
- instr_valid  output  1  FIFO head holds a valid instruction
- instr  output  32  FIFO head instruction word
- instr_pc  output  32  FIFO head instruction address
- instr_ready  input  1  core accepts head this cycle

## Operation
- Registers: fetch_pc (32), FIFO storage of DEPTH × {pc, word}, read/write pointers, count (log2(DEPTH)+1 bits), state.
- States: IDLE (no request), WAIT (request outstanding, response kept), DISCARD (request outstanding, response dropped).
- imem_req = 1 in WAIT or DISCARD. imem_addr = fetch_pc, held stable while imem_req=1.
- IDLE: redirect → fetch_pc ← {redirect_pc[31:2],2'b00}, stay IDLE. Otherwise, if count < DEPTH → WAIT.
- WAIT, no redirect: on imem_ack push {fetch_pc, imem_data}, fetch_pc ← fetch_pc+4 (wraps modulo 2^32). Stay WAIT if count after push and pop < DEPTH, else IDLE. No ack → stay WAIT.
- WAIT, redirect: fetch_pc ← target, FIFO flushed. With imem_ack same cycle → data dropped, IDLE. Without → DISCARD.
- DISCARD: imem_ack → data dropped, IDLE. Redirect in DISCARD updates fetch_pc again; a same-cycle ack still goes to IDLE.
- A request is never withdrawn before its ack.
- Pop when instr_valid && instr_ready. Push and pop in one cycle: count unchanged. Push never occurs with count=DEPTH (space checked at issue).
- Redirect same cycle as pop: pop is a completed transfer; FIFO is then empty.
- imem_ack in IDLE is ignored.

## Timing
- Reset values: imem_req 0, imem_addr RESET_PC, instr_valid 0, instr 0, instr_pc 0, state IDLE, count 0, all FIFO entries 0.
- Reset mid-request: request abandoned, returns to IDLE; later ack ignored.
- instr_valid = (count != 0), registered-equivalent (no combinational path from imem_* or instr_ready).
- Redirect sampled at edge E0 (state IDLE) → imem_req=1, imem_addr=target after E1 → with same-cycle ack, instr_valid=1 and instr_pc=target after E2.
- Zero-wait memory with instr_ready held high: one instruction per cycle sustained.
- FIFO full and no pop: no new request issued until count < DEPTH.

## Configuration
- FETCH_STATS_EN defined: adds outputs stat_fetched (16) and stat_discarded (16), both reset to 0, saturating at 16'hFFFF. stat_fetched increments per push; stat_discarded increments per dropped ack plus the number of entries cleared by a flush.
- Undefined: ports and counters absent; behaviour otherwise identical.

## Test plan
- Reset release, RESET_PC=0, ack tied high, instr_ready=1 → instr_pc sequence 0x0,0x4,0x8… one per cycle from the second cycle after first req.
- instr_ready=0, DEPTH=4, ack tied high → exactly 4 pushes, imem_req low with imem_addr=0x10; raise ready → fetch resumes at 0x10.
- Memory ack delayed 3 cycles; redirect to 0x40 one cycle after request to 0x8 → 0x8 response dropped, next request at 0x40, first delivered instr_pc=0x40.
- Redirect to 0x103 with simultaneous ack of 0x20 in WAIT → ack dropped, next imem_addr=0x100, FIFO empty.
- Assert R low while imem_req=1, then ack arrives → outputs at reset values, no push; fetch restarts at RESET_PC.
- FETCH_STATS_EN: 5 pushes then redirect with 3 buffered entries → stat_fetched=5, stat_discarded=3.
